// File: rtl/m2_block_scheduler.sv
// m2_block_scheduler: overlaps fetch S' / compute T / compute S / write S across the
// 2400 8x8 blocks of a frame (Y 40x30 blocks, U and V 20x30 blocks each).
// Optional feature: define M2_SCHED_WATCHDOG_EN to add a per-state stall watchdog
// that pulses sched_error and returns the scheduler to IDLE.
module m2_block_scheduler (
    input  logic        Clock,
    input  logic        Resetn,
    input  logic        Enable,
    output logic        FS_start,
    input  logic        FS_done,
    output logic        CT_start,
    input  logic        CT_done,
    output logic        CS_start,
    input  logic        CS_done,
    output logic        WS_start,
    input  logic        WS_done,
    output logic [17:0] fs_base_addr,
    output logic [17:0] ws_base_addr,
    output logic [1:0]  segment,
    output logic        sram_sel,
    output logic        busy,
`ifdef M2_SCHED_WATCHDOG_EN
    output logic        sched_error,
`endif
    output logic        done
);

    typedef enum logic [2:0] {
        IDLE, FS_LI, CT_LI, PHASE_A, PHASE_B, CS_LO, WS_LO, DONE
    } state_t;

    state_t      state, state_next;
    logic        entry;
    logic        flag_fs, flag_ct, flag_cs, flag_ws;
    logic        use_fs, use_ct, use_cs, use_ws;
    logic        all_done, fs_adv, ws_adv, restart, wd_trip;
    logic [5:0]  fetch_col, write_col;
    logic [4:0]  fetch_row, write_row;
    logic [1:0]  write_seg;
    logic        fetch_end;
    logic [12:0] fetch_nxt, write_nxt;

    // Column-first raster over the block grid; U/V rows are half as wide as Y.
    function automatic logic [12:0] next_index(input logic [1:0] seg, input logic [4:0] row,
                                               input logic [5:0] col);
        logic [5:0] col_max;
        col_max = (seg == 2'd0) ? 6'd39 : 6'd19;
        if (col != col_max)
            return {seg, row, col + 6'd1};
        else if (row != 5'd29)
            return {seg, row + 5'd1, 6'd0};
        else
            return {seg + 2'd1, 5'd0, 6'd0};
    endfunction

    function automatic logic is_last(input logic [1:0] seg, input logic [4:0] row,
                                     input logic [5:0] col);
        return (seg == 2'd2) && (row == 5'd29) && (col == 6'd19);
    endfunction

    // Coefficient area: Y/U/V planes follow the pixel area, 8 words per block column.
    function automatic logic [17:0] fs_addr(input logic [1:0] seg, input logic [4:0] row,
                                            input logic [5:0] col);
        logic [17:0] base, row_step;
        case (seg)
            2'd0:    begin base = 18'd76800;  row_step = 18'd2560; end
            2'd1:    begin base = 18'd153600; row_step = 18'd1280; end
            default: begin base = 18'd192000; row_step = 18'd1280; end
        endcase
        return base + {13'd0, row} * row_step + {9'd0, col, 3'd0};
    endfunction

    // Pixel area: two pixels per word, so a block column spans 4 words.
    function automatic logic [17:0] ws_addr(input logic [1:0] seg, input logic [4:0] row,
                                            input logic [5:0] col);
        logic [17:0] base, row_step;
        case (seg)
            2'd0:    begin base = 18'd0;     row_step = 18'd1280; end
            2'd1:    begin base = 18'd38400; row_step = 18'd640;  end
            default: begin base = 18'd57600; row_step = 18'd640;  end
        endcase
        return base + {13'd0, row} * row_step + {10'd0, col, 2'd0};
    endfunction

    assign fetch_nxt = next_index(segment, fetch_row, fetch_col);
    assign write_nxt = next_index(write_seg, write_row, write_col);

    // Which stages each state runs, and whether every started stage has reported.
    always_comb begin
        use_fs   = (state == FS_LI) || (state == PHASE_A);
        use_ct   = (state == CT_LI) || (state == PHASE_B);
        use_cs   = (state == PHASE_A) || (state == CS_LO);
        use_ws   = (state == PHASE_B) || (state == WS_LO);
        all_done = (!use_fs || flag_fs || FS_done) && (!use_ct || flag_ct || CT_done) &&
                   (!use_cs || flag_cs || CS_done) && (!use_ws || flag_ws || WS_done);
        fs_adv   = use_fs && FS_done && !flag_fs;
        ws_adv   = use_ws && WS_done && !flag_ws;
        restart  = (state == IDLE) && Enable;
    end

`ifdef M2_SCHED_WATCHDOG_EN
    logic [11:0] wd_cnt;

    // Stall counter: restarts on every state entry and rests at zero in IDLE.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn)
            wd_cnt <= '0;
        else if (state == IDLE || state_next != state)
            wd_cnt <= '0;
        else
            wd_cnt <= wd_cnt + 12'd1;
    end

    assign wd_trip     = (state != IDLE) && (wd_cnt == 12'hFFF);
    assign sched_error = wd_trip;
`else
    assign wd_trip = 1'b0;
`endif

    // State register plus a one-cycle marker for the first cycle of each state.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state <= IDLE;
            entry <= 1'b0;
        end else begin
            state <= state_next;
            entry <= (state_next != state);
        end
    end

    // Next state and all handshake/status outputs.
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        sram_sel   = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (Enable) state_next = FS_LI;
            end
            FS_LI:   if (all_done) state_next = CT_LI;
            CT_LI:   if (all_done) state_next = PHASE_A;
            PHASE_A: if (all_done) state_next = PHASE_B;
            PHASE_B: begin
                sram_sel = 1'b1;
                if (all_done) state_next = fetch_end ? CS_LO : PHASE_A;
            end
            CS_LO:   if (all_done) state_next = WS_LO;
            WS_LO: begin
                sram_sel = 1'b1;
                if (all_done) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (wd_trip) state_next = IDLE;
        FS_start = entry && use_fs;
        CT_start = entry && use_ct;
        CS_start = entry && use_cs;
        WS_start = entry && use_ws;
    end

    // Sticky per-stage done flags; pulses from stages idle in this state are dropped.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            {flag_fs, flag_ct, flag_cs, flag_ws} <= 4'b0;
        end else if (state_next != state) begin
            {flag_fs, flag_ct, flag_cs, flag_ws} <= 4'b0;
        end else begin
            flag_fs <= flag_fs || (use_fs && FS_done);
            flag_ct <= flag_ct || (use_ct && CT_done);
            flag_cs <= flag_cs || (use_cs && CS_done);
            flag_ws <= flag_ws || (use_ws && WS_done);
        end
    end

    // Fetch/write block indices and their registered SRAM base addresses.
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            {segment, fetch_row, fetch_col}     <= '0;
            {write_seg, write_row, write_col}   <= '0;
            fetch_end                           <= 1'b0;
            fs_base_addr                        <= 18'd76800;
            ws_base_addr                        <= 18'd0;
        end else if (restart || wd_trip) begin
            {segment, fetch_row, fetch_col}     <= '0;
            {write_seg, write_row, write_col}   <= '0;
            fetch_end                           <= 1'b0;
            fs_base_addr                        <= 18'd76800;
            ws_base_addr                        <= 18'd0;
        end else begin
            if (fs_adv) begin
                if (is_last(segment, fetch_row, fetch_col)) begin
                    fetch_end <= 1'b1;
                end else begin
                    {segment, fetch_row, fetch_col} <= fetch_nxt;
                    fs_base_addr <= fs_addr(fetch_nxt[12:11], fetch_nxt[10:6], fetch_nxt[5:0]);
                end
            end
            if (ws_adv && !is_last(write_seg, write_row, write_col)) begin
                {write_seg, write_row, write_col} <= write_nxt;
                ws_base_addr <= ws_addr(write_nxt[12:11], write_nxt[10:6], write_nxt[5:0]);
            end
        end
    end

endmodule

// File: tb/tb_m2_block_scheduler.sv
// tb_m2_block_scheduler: randomized stage responders, frame-level reference model
// (block number -> plane/row/col -> address) and a scoreboard of expected start events.
module tb_m2_block_scheduler;

    logic        Clock, Resetn, Enable;
    logic        FS_start, FS_done, CT_start, CT_done, CS_start, CS_done, WS_start, WS_done;
    logic [17:0] fs_base_addr, ws_base_addr;
    logic [1:0]  segment;
    logic        sram_sel, busy, done;
`ifdef M2_SCHED_WATCHDOG_EN
    logic        sched_error;
`endif

    m2_block_scheduler dut (
        .Clock(Clock), .Resetn(Resetn), .Enable(Enable),
        .FS_start(FS_start), .FS_done(FS_done),
        .CT_start(CT_start), .CT_done(CT_done),
        .CS_start(CS_start), .CS_done(CS_done),
        .WS_start(WS_start), .WS_done(WS_done),
        .fs_base_addr(fs_base_addr), .ws_base_addr(ws_base_addr),
        .segment(segment), .sram_sel(sram_sel), .busy(busy),
`ifdef M2_SCHED_WATCHDOG_EN
        .sched_error(sched_error),
`endif
        .done(done)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    typedef struct {
        logic [3:0]  st;   // {WS, CS, CT, FS} start pulses
        logic        dn;
        logic        ss;
        logic [17:0] fa;
        logic [1:0]  sg;
        logic [17:0] wa;
    } ev_t;

    localparam int FS_BASE   [3] = '{76800, 153600, 192000};
    localparam int FS_STRIDE [3] = '{320, 160, 160};
    localparam int WS_BASE   [3] = '{0, 38400, 57600};
    localparam int WS_STRIDE [3] = '{160, 80, 80};

    ev_t  exp_q[$];
    int   n_tests, n_fail;
    int   done_seen;
    logic mon_en, hold_ct;
    int   pa_cnt;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp_v);
        end
    endtask

    // Frame geometry: blocks 0..1199 are Y (40 wide), then 600 U, then 600 V (20 wide).
    function automatic void geom(input int b, output int seg, output int row, output int col);
        int loc;
        if (b < 1200) begin
            seg = 0; row = b / 40; col = b % 40;
        end else begin
            seg = 1 + (b - 1200) / 600;
            loc = (b - 1200) % 600;
            row = loc / 20; col = loc % 20;
        end
    endfunction

    function automatic ev_t mk(input logic [3:0] st, input int fb, input int wb);
        ev_t e;
        int  s, r, c;
        e.st = st; e.dn = 1'b0; e.ss = st[3]; e.fa = '0; e.sg = '0; e.wa = '0;
        if (fb >= 0) begin
            geom(fb, s, r, c);
            e.fa = 18'(FS_BASE[s] + r * 8 * FS_STRIDE[s] + c * 8);
            e.sg = 2'(s);
        end
        if (wb >= 0) begin
            geom(wb, s, r, c);
            e.wa = 18'(WS_BASE[s] + r * 8 * WS_STRIDE[s] + c * 4);
        end
        return e;
    endfunction

    // Whole-frame schedule: lead-in, 2399 overlapped A/B pairs, lead-out, done.
    task automatic push_run();
        ev_t e;
        exp_q.push_back(mk(4'b0001, 0, -1));
        exp_q.push_back(mk(4'b0010, -1, -1));
        for (int n = 0; n < 2399; n++) begin
            exp_q.push_back(mk(4'b0101, n + 1, -1));
            exp_q.push_back(mk(4'b1010, -1, n));
        end
        exp_q.push_back(mk(4'b0100, -1, -1));
        exp_q.push_back(mk(4'b1000, -1, 2399));
        e = mk(4'b0000, -1, -1);
        e.dn = 1'b1;
        exp_q.push_back(e);
    endtask

    // Stage responders: answer each start after a chosen delay; PHASE_A gets special timings.
    initial begin : responder
        int         cnt [4];
        int         dl  [4];
        logic [3:0] st, ds;
        int         r;
        for (int i = 0; i < 4; i++) cnt[i] = -1;
        pa_cnt = 0;
        {WS_done, CS_done, CT_done, FS_done} = 4'b0;
        forever begin
            @(negedge Clock);
            ds = 4'b0;
            if (Resetn !== 1'b1) begin
                for (int i = 0; i < 4; i++) cnt[i] = -1;
            end else begin
                st = {WS_start, CS_start, CT_start, FS_start};
                for (int i = 0; i < 4; i++) dl[i] = $urandom_range(0, 2);
                if (st[0] && st[2]) begin
                    r = $urandom_range(0, 63);
                    if (pa_cnt == 0) begin
                        dl[0] = 2; dl[2] = 2;
                    end else if (pa_cnt == 1 || (pa_cnt > 3 && r == 0)) begin
                        dl[0] = 0; dl[2] = 50;
                    end else if (pa_cnt == 2) begin
                        dl[0] = 50; dl[2] = 0;
                    end else if (pa_cnt == 3 || r == 1) begin
                        ds[3] = 1'b1;
                    end
                    pa_cnt++;
                end
                for (int i = 0; i < 4; i++)
                    if (st[i] && !(i == 1 && hold_ct)) cnt[i] = dl[i];
                for (int i = 0; i < 4; i++) begin
                    if (cnt[i] == 0) begin
                        ds[i] = 1'b1; cnt[i] = -1;
                    end else if (cnt[i] > 0) begin
                        cnt[i]--;
                    end
                end
            end
            {WS_done, CS_done, CT_done, FS_done} = ds;
        end
    end

    // Monitor: every cycle showing a start or done pops and compares one expected event.
    initial begin : monitor
        ev_t        e;
        logic [3:0] st;
        done_seen = 0;
        forever begin
            @(negedge Clock);
            if (mon_en && Resetn === 1'b1) begin
                st = {WS_start, CS_start, CT_start, FS_start};
`ifdef M2_SCHED_WATCHDOG_EN
                check("sched_error_quiet", sched_error, 0);
`endif
                if (st != 4'b0 || done) begin
                    check("event_expected", exp_q.size() > 0, 1);
                    if (exp_q.size() > 0) begin
                        e = exp_q.pop_front();
                        check("starts", st, e.st);
                        check("done", done, e.dn);
                        check("busy", busy, 1);
                        check("sram_sel", sram_sel, e.ss);
                        if (e.st[0]) begin
                            check("fs_base_addr", fs_base_addr, e.fa);
                            check("segment", segment, e.sg);
                        end
                        if (e.st[3]) check("ws_base_addr", ws_base_addr, e.wa);
                        if (e.dn) done_seen++;
                    end
                end
            end
        end
    end

    task automatic check_reset_values(input string tag);
        check({tag, "_starts"}, {WS_start, CS_start, CT_start, FS_start}, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_sram_sel"}, sram_sel, 0);
        check({tag, "_fs_base_addr"}, fs_base_addr, 76800);
        check({tag, "_ws_base_addr"}, ws_base_addr, 0);
        check({tag, "_segment"}, segment, 0);
    endtask

    task automatic run_full(input bit poke);
        int d0;
        d0 = done_seen;
        exp_q.delete();
        push_run();
        mon_en = 1'b1;
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        for (int c = 0; c < 60000; c++) begin
            @(negedge Clock);
            Enable = (poke && c == 200);
            if (done_seen != d0) break;
        end
        Enable = 1'b0;
        check("run_completed", done_seen - d0, 1);
        @(negedge Clock);
        check("busy_after_done", busy, 0);
        check("done_after_done", done, 0);
        check("queue_drained", exp_q.size(), 0);
    endtask

    initial begin : main
        int k;
        bit found;
        n_tests = 0; n_fail = 0;
        Resetn = 1'b0; Enable = 1'b0; mon_en = 1'b0; hold_ct = 1'b0;
        repeat (3) @(negedge Clock);
        check_reset_values("reset");
        Resetn = 1'b1;
        @(negedge Clock);
        check("idle_busy", busy, 0);

        // Full frame with a stray Enable pulse mid-run.
        run_full(1'b1);

        // Partial frame, then asynchronous reset on the first cycle of a PHASE_B.
        exp_q.delete();
        push_run();
        mon_en = 1'b1;
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        found = 1'b0;
        k = 0;
        for (int c = 0; c < 5000; c++) begin
            @(negedge Clock);
            if (WS_start) k++;
            if (WS_start && k >= 10) begin
                found = 1'b1;
                break;
            end
        end
        check("reached_phase_b", found, 1);
        check("phase_b_sram_sel", sram_sel, 1);
        mon_en = 1'b0;
        #2 Resetn = 1'b0;
        #1;
        check_reset_values("midrun_reset");
        exp_q.delete();
        repeat (2) @(negedge Clock);
        Resetn = 1'b1;
        @(negedge Clock);

        // Restart from block 0 after the reset.
        run_full(1'b0);

`ifdef M2_SCHED_WATCHDOG_EN
        // Withhold CT_done so the watchdog fires in CT_LI.
        mon_en = 1'b0;
        hold_ct = 1'b1;
        Enable = 1'b1;
        @(negedge Clock);
        Enable = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 200; c++) begin
            if (CT_start) begin
                found = 1'b1;
                break;
            end
            @(negedge Clock);
        end
        check("wd_ct_started", found, 1);
        k = 0;
        while (sched_error !== 1'b1 && k < 5000) begin
            @(negedge Clock);
            k++;
        end
        check("wd_cycles", k, 4095);
        @(negedge Clock);
        check("wd_error_pulse", sched_error, 0);
        check_reset_values("wd_idle");
        hold_ct = 1'b0;
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/m2_block_scheduler.md
M2_BLOCK_SCHEDULER -- requirements
Module: m2_block_scheduler

Interface
REQ-001 SHALL have ports, clock and reset first: Clock in 1 (system clock); Resetn in 1 (asynchronous, active-low reset); Enable in 1 (start pulse).
REQ-002 SHALL have stage handshakes: FS_start out 1, FS_done in 1 (fetch S'); CT_start out 1, CT_done in 1 (compute T); CS_start out 1, CS_done in 1 (compute S); WS_start out 1, WS_done in 1 (write S).
REQ-003 SHALL have outputs: fs_base_addr out 18 (SRAM address of the fetch block's top-left coefficient); ws_base_addr out 18 (SRAM word address of the write block's top-left pixel pair); segment out 2 (fetch block's plane: 0=Y, 1=U, 2=V); sram_sel out 1 (0=FS owns SRAM, 1=WS owns SRAM); busy out 1; done out 1 (one-cycle completion pulse).
REQ-004 SHALL have no parameters; the geometry is fixed: Y has 40x30 blocks and U/V have 20x30 blocks each, 2400 blocks in total.

Function
REQ-005 SHALL use states IDLE, FS_LI, CT_LI, PHASE_A (CS n and FS n+1), PHASE_B (CT n+1 and WS n), CS_LO, WS_LO, DONE.
REQ-006 SHALL move IDLE->FS_LI on Enable=1; Enable while busy=1 SHALL be ignored.
REQ-007 SHALL pulse each stage start for exactly one cycle, on the first cycle of a state that uses that stage.
REQ-008 SHALL hold one sticky done flag per stage, cleared at state entry and set by the matching done pulse; a done pulse from a stage not started in the current state SHALL be ignored.
REQ-009 SHALL leave a state only when the flags of all started stages are set; done pulses arriving in the same cycle, or in either order, SHALL be accepted.
REQ-010 SHALL follow the transitions FS_LI->CT_LI->PHASE_A->PHASE_B->PHASE_A...; PHASE_B SHALL go to CS_LO once the fetch index has passed block 2399; CS_LO->WS_LO->DONE->IDLE.
REQ-011 SHALL keep a fetch index (col, row, segment) and a write index; after each FS completion the fetch index SHALL advance col-first and wrap at 40 (Y) or 20 (U/V); at row 30 it SHALL move to the next segment at col 0, row 0; the write index SHALL advance identically after each WS completion.
REQ-012 SHALL compute fs_base_addr = seg_base + row*8*stride + col*8, with seg_base 76800/153600/192000 and stride 320/160/160 for Y/U/V.
REQ-013 SHALL compute ws_base_addr = seg_base + row*8*stride + col*4, with seg_base 0/38400/57600 and stride 160/80/80.
REQ-014 SHALL register both addresses, valid from the cycle the corresponding start pulse is asserted until the next index change.
REQ-015 SHALL drive sram_sel=1 only in PHASE_B and WS_LO, and sram_sel=0 otherwise; FS and WS SHALL never be active in the same state.
REQ-016 SHALL drive busy=1 in every state except IDLE, and assert done for one cycle in DONE.
REQ-017 SHALL use unsigned arithmetic with intermediate products of at least 18 bits; the largest address is 229272, which is less than 2^18.

Reset
REQ-018 SHALL, on Resetn=0 (including mid-operation): enter IDLE; drive all start outputs, busy, done and sram_sel to 0; clear segment, both indices and all sticky flags; set fs_base_addr=76800 and ws_base_addr=0.

Configuration
REQ-019 SHALL implement a watchdog when M2_SCHED_WATCHDOG_EN is defined: a 12-bit counter, cleared at state entry, counts cycles spent in any non-IDLE state.
REQ-020 SHALL, with M2_SCHED_WATCHDOG_EN defined, when the counter reaches 4095: add output sched_error (1 bit), pulse it for one cycle and force IDLE with the REQ-018 values.
REQ-021 SHALL, with M2_SCHED_WATCHDOG_EN undefined, have no sched_error port and wait indefinitely for done pulses.

Verification
REQ-022 Enable pulse from reset -> FS_start one cycle later with fs_base_addr=76800, segment=0, sram_sel=0.
REQ-023 FS done for Y block col 39 row 0 -> next FS_start shows fs_base_addr=79360; the matching write block (col 0 row 1) shows ws_base_addr=1280.
REQ-024 Fetch index at block 1200 (first U) -> fs_base_addr=153600, segment=1; its WS shows ws_base_addr=38400.
REQ-025 Last block (V col 19 row 29) -> fs_base_addr=229272, ws_base_addr=76236; then CS_LO, WS_LO, done pulse, busy=0.
REQ-026 PHASE_A with CS_done and FS_done in the same cycle, and separately with CS_done 50 cycles after FS_done -> exactly one transition to PHASE_B; a stray WS_done in PHASE_A is ignored.
REQ-027 Resetn=0 during PHASE_B -> all outputs at reset values immediately; Enable then restarts at block 0. With M2_SCHED_WATCHDOG_EN defined, withholding CT_done -> sched_error pulses after 4095 cycles and the block returns to IDLE.
